rf_write_mux: RTL
=================

# rf_write_mux

Write-side counterpart of the register-file read multiplexer. It accepts up to VIRT_WRITES register-file write requests per cycle from result producers and buffers each requester in a small private FIFO. Each cycle it drains up to PHY_WRITES buffered writes onto the physical register-file write ports, chosen by round-robin. It sits between the execution/load result buses and the physical register file.

## Interface
Parameters:
- VIRT_WRITES, 4, number of requester (virtual) write ports; must be ≥ PHY_WRITES.
- PHY_WRITES, 2, number of physical register-file write ports; must be ≥ 1.
- BUF_DEPTH, 4, per-requester FIFO depth; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IN_write  in  VIRT_WRITES × RF_WriteReq  per requester: valid, tag (RFTag), data (RegT).
- OUT_writeReady  out  VIRT_WRITES  the requester may present a write this cycle.
- OUT_writeEnable  out  PHY_WRITES  the physical port writes this cycle.
- OUT_writeAddress  out  PHY_WRITES × RFTag  write tag per physical port.
- OUT_writeData  out  PHY_WRITES × RegT  write data per physical port.
- OUT_idle  out  1  all FIFOs are empty and no physical write is enabled.

## Operation
- **State per requester i:** FIFO storage of BUF_DEPTH entries of {tag, data}, read and write pointers of $clog2(BUF_DEPTH) bits that wrap modulo BUF_DEPTH, and count[i] of $clog2(BUF_DEPTH)+1 bits.
- **Ready:** OUT_writeReady[i] = (count[i] < BUF_DEPTH). It uses the registered count only; a drain in the same cycle gives no credit.
- **Enqueue:** occurs when IN_write[i].valid && OUT_writeReady[i]. If valid is high while ready is low, the request is ignored; holding the request is the requester's responsibility.
- **Drain selection:** combinational, from registered counts. Scan requesters starting at rrPtr and wrapping modulo VIRT_WRITES. The first PHY_WRITES requesters with count > 0 are granted, and the k-th grant is assigned to physical port k.
  - Each granted requester pops exactly one entry per cycle.
  - Data enqueued this cycle is not eligible for drain until the next cycle; there is no bypass.
- **Output register:** the popped {tag, data} for port k is registered into OUT_writeAddress[k] and OUT_writeData[k], and OUT_writeEnable[k] is set to 1. Ports without a grant register enable = 0; their address and data hold their previous values.
- **rrPtr update:** if at least one grant occurs, rrPtr becomes (index of last granted requester + 1) mod VIRT_WRITES. With no grants, rrPtr is unchanged.
- **count update:** count[i] += push − pop, where push and pop may both occur in the same cycle.
- **Ordering:** writes from a single requester reach the physical ports in acceptance order. No ordering is guaranteed between different requesters.
- **Idle:** OUT_idle = (all count == 0) && (OUT_writeEnable == 0).
- **Reset (async, any time, including mid-drain):** all counts, pointers and rrPtr are cleared to 0. OUT_writeEnable is cleared to 0, OUT_writeAddress and OUT_writeData to 0, OUT_writeReady to all-ones, and OUT_idle to 1. Buffered writes are discarded.

## Timing
- **Latency:** a write accepted at edge E is popped at the earliest at edge E+1. It is visible on the physical port in the cycle after edge E+1, so the latency is 2 edges when uncontested.
- **Throughput:** each requester sustains 1 write per cycle only while it is granted every cycle. Aggregate drain is ≤ PHY_WRITES per cycle.
- **Ready response:** OUT_writeReady[i] deasserts in the cycle after the enqueue that makes count[i] == BUF_DEPTH. It reasserts in the cycle after the first pop from that full FIFO.
- **Full FIFO with simultaneous push and pop:** this cannot happen, because ready is low when the FIFO is full.
- **Fairness:** a non-empty requester is granted within ceil(VIRT_WRITES / PHY_WRITES) cycles.
- **Degenerate case:** with VIRT_WRITES == PHY_WRITES, every non-empty FIFO is granted every cycle.

## Test plan
- **Single write.** Stimulus: default parameters; requester 2 writes tag 5, data 0xDEAD at edge 1, all others idle. Required response: OUT_writeEnable = 2'b01, address 5, data 0xDEAD during the cycle after edge 2, then enable = 0. OUT_idle is 0 from edge 1 until edge 3.
- **Backpressure.** Stimulus: BUF_DEPTH = 2, PHY_WRITES = 1; requesters 0 and 1 both stream writes every cycle. Required response:
  - OUT_writeReady[0] drops after its FIFO fills.
  - No write is accepted while ready is low.
  - All accepted writes appear exactly once.
- **Round-robin.** Stimulus: VIRT_WRITES = 4, PHY_WRITES = 1; all four FIFOs preloaded with 2 entries each. Required response: grant order on port 0 is requester 0,1,2,3,0,1,2,3 over 8 consecutive cycles.
- **Per-requester order.** Stimulus: requester 3 enqueues tags 10, 11, 12, 13 on consecutive cycles while requesters 0–2 saturate the ports. Required response: tags 10–13 appear in order, and each within 2 cycles of its fair turn.
- **Mid-operation reset.** Stimulus: rst_n asserted with FIFOs partially full and OUT_writeEnable = 2'b11. Required response:
  - Outputs clear immediately, without waiting for clk.
  - After release, no stale write is ever emitted.
  - OUT_writeReady is all-ones and OUT_idle is 1.
- **Simultaneous push and pop.** Stimulus: requester 1 at count 1 pushes while being granted. Required response: count stays 1, and the old head drains before the new entry.

Source files
------------

// File: rtl/rf_write_mux.sv
// Register-file write multiplexer: per-requester write FIFOs drained onto a
// smaller set of physical write ports by a round-robin selector.
// Each IN_write[i] element is packed as {valid, tag[TAG_W-1:0], data[DATA_W-1:0]}.
module rf_write_mux #(
    parameter int unsigned VIRT_WRITES = 4,
    parameter int unsigned PHY_WRITES  = 2,
    parameter int unsigned BUF_DEPTH   = 4,
    parameter int unsigned TAG_W       = 7,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [VIRT_WRITES-1:0][TAG_W+DATA_W:0]    IN_write,
    output logic [VIRT_WRITES-1:0]                    OUT_writeReady,
    output logic [PHY_WRITES-1:0]                     OUT_writeEnable,
    output logic [PHY_WRITES-1:0][TAG_W-1:0]          OUT_writeAddress,
    output logic [PHY_WRITES-1:0][DATA_W-1:0]         OUT_writeData,
    output logic                                      OUT_idle
);

    localparam int unsigned ENTRY_W = TAG_W + DATA_W;
    localparam int unsigned PTR_W   = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RR_W    = (VIRT_WRITES > 1) ? $clog2(VIRT_WRITES) : 1;

    logic [ENTRY_W-1:0] mem_q [VIRT_WRITES][BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [VIRT_WRITES];
    logic [PTR_W-1:0]   rd_ptr_q [VIRT_WRITES];
    logic [CNT_W-1:0]   count_q  [VIRT_WRITES];
    logic [RR_W-1:0]    rr_q, rr_d;

    logic [VIRT_WRITES-1:0]           push, pop, nonempty;
    logic [PHY_WRITES-1:0]            port_vld;
    logic [PHY_WRITES-1:0][RR_W-1:0]  port_src;

    // Ready, push qualification and occupancy flags from registered counts only.
    always_comb begin
        push           = '0;
        nonempty       = '0;
        OUT_writeReady = '0;
        for (int i = 0; i < int'(VIRT_WRITES); i++) begin
            OUT_writeReady[i] = (count_q[i] < CNT_W'(BUF_DEPTH));
            nonempty[i]       = (count_q[i] != '0);
            push[i]           = IN_write[i][ENTRY_W] && OUT_writeReady[i];
        end
    end

    // Round-robin scan from rr_q: the k-th non-empty requester found drives port k.
    always_comb begin
        int          n;
        int          idx;
        int          last;
        logic [RR_W-1:0] sel;
        pop      = '0;
        port_vld = '0;
        port_src = '0;
        n        = 0;
        last     = 0;
        sel      = '0;
        for (int j = 0; j < int'(VIRT_WRITES); j++) begin
            idx = (int'(rr_q) + j) % int'(VIRT_WRITES);
            sel = RR_W'(idx);
            if (nonempty[sel] && (n < int'(PHY_WRITES))) begin
                pop[sel] = 1'b1;
                for (int k = 0; k < int'(PHY_WRITES); k++) begin
                    if (n == k) begin
                        port_src[k] = sel;
                        port_vld[k] = 1'b1;
                    end
                end
                n    = n + 1;
                last = idx;
            end
        end
        rr_d = (n != 0) ? RR_W'((last + 1) % int'(VIRT_WRITES)) : rr_q;
    end

    // FIFO payload storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(VIRT_WRITES); i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= IN_write[i][ENTRY_W-1:0];
            end
        end
    end

    // FIFO pointers, counts and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(VIRT_WRITES); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int i = 0; i < int'(VIRT_WRITES); i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            rr_q <= rr_d;
        end
    end

    // Registered physical write ports; ungranted ports hold address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT_writeEnable  <= '0;
            OUT_writeAddress <= '0;
            OUT_writeData    <= '0;
        end else begin
            for (int k = 0; k < int'(PHY_WRITES); k++) begin
                OUT_writeEnable[k] <= port_vld[k];
                if (port_vld[k]) begin
                    {OUT_writeAddress[k], OUT_writeData[k]} <=
                        mem_q[port_src[k]][rd_ptr_q[port_src[k]]];
                end
            end
        end
    end

    // Idle once every FIFO is empty and no port is writing.
    always_comb begin
        OUT_idle = (nonempty == '0) && (OUT_writeEnable == '0);
    end

endmodule
